x_dcr_regfile: RTL and testbench
================================

X_DCR_REGFILE -- requirements
Module: x_dcr_regfile

Interface
REQ-001 Parameter BASE_ADDR, default 10'h000, is the DCR base address; the low 2 bits SHALL be zero and the block occupies BASE_ADDR..BASE_ADDR+3.
REQ-002 Parameter ACK_LATENCY, default 1, sets wait cycles before acknowledge; legal range is 0..3.
REQ-003 Parameter CTRL_RST, default 32'h0000_0000, is the reset value of the CTRL register.
REQ-004 CLK  in  1  single block clock, the DCR clock of the processor core.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 DCRABUS  in  [0:9]  DCR address from the core's DCR address output.
REQ-007 DCRDBUSIN  in  [0:31]  write data / chain data from the core's DCR data output.
REQ-008 DCRREAD  in  1  read request; held until acknowledge.
REQ-009 DCRWRITE  in  1  write request; held until acknowledge.
REQ-010 DCRACK  out  1  acknowledge to the core's DCR ack input.
REQ-011 DCRDBUSOUT  out  [0:31]  read data to the core's DCR data input.
REQ-012 STATUS  in  [0:31]  live status word.
REQ-013 EVENT  in  1  single-cycle event strobe.
REQ-014 CTRL  out  [0:31]  current CTRL register value.
REQ-015 Bit 0 SHALL be the MSB on all buses, and bit 31 the LSB.

Function
REQ-016 Register map at offsets 0..3 SHALL be: CTRL (RW), STATUS (RO, sampled), SCRATCH (RW), EVCNT (RO, clear-on-read).
REQ-017 A hit SHALL be DCRABUS[0:7] == BASE_ADDR[0:7].
REQ-018 The FSM SHALL have exactly three states: IDLE, WAIT, ACK.
REQ-019 IDLE -> WAIT SHALL occur when exactly one of DCRREAD/DCRWRITE is high and the address hits; with ACK_LATENCY=0, IDLE SHALL go directly to ACK.
REQ-020 WAIT SHALL hold for ACK_LATENCY-1 further cycles and then go to ACK, so DCRACK rises ACK_LATENCY+1 cycles after the request is first sampled.
REQ-021 On entry to ACK, a write SHALL commit DCRDBUSIN to CTRL/SCRATCH, and a read SHALL capture the addressed register into a read-data register.
REQ-022 A write to STATUS or EVCNT SHALL be acknowledged with no effect.
REQ-023 In ACK, DCRACK SHALL be 1, and the FSM SHALL stay in ACK until DCRREAD and DCRWRITE are both low, then return to IDLE.
REQ-024 DCRACK SHALL be registered, and SHALL be 0 in IDLE and WAIT.
REQ-025 DCRDBUSOUT SHALL equal the read-data register while a read is in ACK; otherwise it SHALL equal DCRDBUSIN (daisy-chain pass-through).
REQ-026 DCRREAD and DCRWRITE both high in IDLE SHALL be ignored: no ack, no state change.
REQ-027 A request that drops in WAIT SHALL abort to IDLE with no register update.
REQ-028 EVCNT SHALL be a 16-bit counter in bits [16:31], with bits [0:15] reading 0, and SHALL saturate at 16'hFFFF.
REQ-029 A read of EVCNT SHALL return the pre-clear value and clear the counter on ACK entry; an EVENT in that same cycle SHALL leave the counter at 1.

Reset
REQ-030 RST_N low SHALL immediately force: FSM to IDLE, DCRACK=0, CTRL=CTRL_RST, SCRATCH=0, EVCNT=0, read-data register=0.
REQ-031 Reset mid-access SHALL discard the access; after release, a still-held request SHALL be re-sampled as new.

Configuration
REQ-032 With macro X_DCR_REGFILE_EVCNT_EN defined, EVCNT SHALL behave per REQ-028/029.
REQ-033 With X_DCR_REGFILE_EVCNT_EN undefined, the counter logic SHALL be absent, EVENT SHALL be ignored, and offset 3 SHALL read 32'h0 while still being acknowledged.

Structure
REQ-034 Package x_dcr_pkg SHALL hold the register offset constants, the FSM state typedef, and the DCR address/data widths (10, 32).
REQ-035 The event counter SHALL be a sub-module x_dcr_evcnt (count, saturate, clear); everything else SHALL be flat.

Verification
REQ-036 Write 32'hDEAD_BEEF to BASE+0, ACK_LATENCY=1 -> DCRACK rises 2 cycles after DCRWRITE is sampled; CTRL=32'hDEAD_BEEF; ack falls the cycle after DCRWRITE drops.
REQ-037 Read BASE+1 with STATUS=32'h1234_5678, ACK_LATENCY=0 -> ack after 1 cycle with DCRDBUSOUT=32'h1234_5678; a non-hit address produces no ack and DCRDBUSOUT=DCRDBUSIN.
REQ-038 Pulse EVENT 70000 times, then read BASE+3 -> 32'h0000_FFFF; an immediate second read with EVENT high on the clear cycle -> 32'h0000_0001.
REQ-039 DCRREAD and DCRWRITE high together at BASE+2 -> no ack for 10 cycles and SCRATCH unchanged.
REQ-040 Assert RST_N low while in ACK during a write to SCRATCH -> DCRACK=0 in the same cycle, SCRATCH=0, CTRL=CTRL_RST.
REQ-041 Build without X_DCR_REGFILE_EVCNT_EN, pulse EVENT, read BASE+3 -> acknowledged with 32'h0.

Source files
------------

// File: rtl/x_dcr_pkg.sv
// Shared constants and types for the x_dcr_regfile DCR slave.
// Register offsets, FSM state type and DCR bus widths.
package x_dcr_pkg;

  localparam int unsigned DcrAddrW = 10;
  localparam int unsigned DcrDataW = 32;
  localparam int unsigned EvcntW   = 16;

  localparam logic [1:0] OffCtrl    = 2'd0;
  localparam logic [1:0] OffStatus  = 2'd1;
  localparam logic [1:0] OffScratch = 2'd2;
  localparam logic [1:0] OffEvcnt   = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } dcr_state_e;

endpackage

// File: rtl/x_dcr_evcnt.sv
// Saturating event counter with clear; an increment coinciding with a clear leaves 1.
module x_dcr_evcnt
  import x_dcr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [EvcntW-1:0] count
);

  logic [EvcntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= {{(EvcntW-1){1'b0}}, inc};
    end else if (inc && (cnt_q != {EvcntW{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/x_dcr_regfile.sv
// Four-register DCR slave (CTRL, STATUS, SCRATCH, EVCNT) with daisy-chain data pass-through.
// Define X_DCR_REGFILE_EVCNT_EN to include the EVCNT event counter; otherwise offset 3 reads 0.
module x_dcr_regfile
  import x_dcr_pkg::*;
#(
  parameter logic [0:DcrAddrW-1] BASE_ADDR   = 10'h000,
  parameter int unsigned         ACK_LATENCY = 1,
  parameter logic [0:DcrDataW-1] CTRL_RST    = 32'h0000_0000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [0:DcrAddrW-1] DCRABUS,
  input  logic [0:DcrDataW-1] DCRDBUSIN,
  input  logic                DCRREAD,
  input  logic                DCRWRITE,
  output logic                DCRACK,
  output logic [0:DcrDataW-1] DCRDBUSOUT,
  input  logic [0:DcrDataW-1] STATUS,
  input  logic                EVENT,
  output logic [0:DcrDataW-1] CTRL
);

  dcr_state_e          state_q;
  logic [1:0]          wait_q;
  logic                rd_q;
  logic [1:0]          off_q;
  logic [0:DcrDataW-1] ctrl_q, scratch_q, rdata_q;
  logic                ack_q;

  logic                hit, start, held, go_ack, acc_rd;
  logic [1:0]          acc_off;
  logic [0:DcrDataW-1] evcnt_val, rd_mux;

  assign hit   = (DCRABUS[0:7] == BASE_ADDR[0:7]);
  assign start = (state_q == StIdle) && hit && (DCRREAD ^ DCRWRITE);
  assign held  = rd_q ? DCRREAD : DCRWRITE;

  // With zero latency the commit happens on the sampling edge, so use the live bus.
  assign acc_rd  = (state_q == StIdle) ? DCRREAD : rd_q;
  assign acc_off = (state_q == StIdle) ? DCRABUS[8:9] : off_q;

  always_comb begin
    go_ack = 1'b0;
    unique case (state_q)
      StIdle:  go_ack = start && (ACK_LATENCY == 0);
      StWait:  go_ack = held && (wait_q == 2'd0);
      default: go_ack = 1'b0;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (acc_off)
      OffCtrl:    rd_mux = ctrl_q;
      OffStatus:  rd_mux = STATUS;
      OffScratch: rd_mux = scratch_q;
      default:    rd_mux = evcnt_val;
    endcase
  end

`ifdef X_DCR_REGFILE_EVCNT_EN
  logic              ev_clr;
  logic [EvcntW-1:0] ev_count;

  assign ev_clr = go_ack && acc_rd && (acc_off == OffEvcnt);

  x_dcr_evcnt u_evcnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (EVENT),
    .clr   (ev_clr),
    .count (ev_count)
  );

  assign evcnt_val = {{(DcrDataW-EvcntW){1'b0}}, ev_count};
`else
  logic unused_event;
  assign unused_event = EVENT;
  assign evcnt_val    = '0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      wait_q    <= 2'd0;
      rd_q      <= 1'b0;
      off_q     <= 2'd0;
      ctrl_q    <= CTRL_RST;
      scratch_q <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            rd_q  <= DCRREAD;
            off_q <= DCRABUS[8:9];
            if (ACK_LATENCY == 0) begin
              state_q <= StAck;
            end else begin
              state_q <= StWait;
              wait_q  <= 2'(ACK_LATENCY - 1);
            end
          end
        end
        StWait: begin
          if (!held) begin
            state_q <= StIdle;
          end else if (wait_q == 2'd0) begin
            state_q <= StAck;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        StAck: begin
          if (!DCRREAD && !DCRWRITE) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Commit or capture exactly once, on entry to StAck.
      if (go_ack) begin
        ack_q <= 1'b1;
        if (acc_rd) begin
          rdata_q <= rd_mux;
        end else if (acc_off == OffCtrl) begin
          ctrl_q <= DCRDBUSIN;
        end else if (acc_off == OffScratch) begin
          scratch_q <= DCRDBUSIN;
        end
      end
    end
  end

  assign DCRACK     = ack_q;
  assign DCRDBUSOUT = ((state_q == StAck) && rd_q) ? rdata_q : DCRDBUSIN;
  assign CTRL       = ctrl_q;

endmodule

// File: tb/tb_x_dcr_regfile.sv
// Self-checking bench: two instances (ACK_LATENCY 0 and 1) against a register-level model.
module tb_x_dcr_regfile;

  localparam logic [0:9]  Base0    = 10'h000;
  localparam logic [0:9]  Base1    = 10'h140;
  localparam logic [0:31] CtrlRst1 = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:9]  abus   [2];
  logic [0:31] dbin   [2];
  logic [0:31] status [2];
  logic        rd     [2];
  logic        wr     [2];
  logic        ev     [2];
  logic        ack0, ack1;
  logic [0:31] dbout0, dbout1, ctrl0, ctrl1;

  int          vectors = 0;
  int          errors  = 0;
  logic [0:31] ctrl_m    [2];
  logic [0:31] scratch_m [2];
  int          evcnt_m   [2];

  always #5 clk = ~clk;

  x_dcr_regfile #(.BASE_ADDR(Base0), .ACK_LATENCY(0), .CTRL_RST(32'h0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .DCRABUS(abus[0]), .DCRDBUSIN(dbin[0]), .DCRREAD(rd[0]),
    .DCRWRITE(wr[0]), .DCRACK(ack0), .DCRDBUSOUT(dbout0), .STATUS(status[0]),
    .EVENT(ev[0]), .CTRL(ctrl0)
  );

  x_dcr_regfile #(.BASE_ADDR(Base1), .ACK_LATENCY(1), .CTRL_RST(CtrlRst1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .DCRABUS(abus[1]), .DCRDBUSIN(dbin[1]), .DCRREAD(rd[1]),
    .DCRWRITE(wr[1]), .DCRACK(ack1), .DCRDBUSOUT(dbout1), .STATUS(status[1]),
    .EVENT(ev[1]), .CTRL(ctrl1)
  );

  function automatic logic get_ack(input int d);
    return (d != 0) ? ack1 : ack0;
  endfunction

  function automatic logic [0:31] get_dbout(input int d);
    return (d != 0) ? dbout1 : dbout0;
  endfunction

  function automatic logic [0:31] get_ctrl(input int d);
    return (d != 0) ? ctrl1 : ctrl0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ctrl_m[0] = 32'h0;
    ctrl_m[1] = CtrlRst1;
    for (int i = 0; i < 2; i++) begin
      scratch_m[i] = '0;
      evcnt_m[i]   = 0;
    end
  endtask

  // Expected read value; EVCNT reads clear the modelled count (to 1 if an event hit that edge).
  task automatic model_read(input int d, input logic [1:0] off, input bit ev_entry,
                            output logic [0:31] exp);
    case (off)
      2'd0:    exp = ctrl_m[d];
      2'd1:    exp = status[d];
      2'd2:    exp = scratch_m[d];
      default: begin
`ifdef X_DCR_REGFILE_EVCNT_EN
        exp = (evcnt_m[d] > 65535) ? 32'h0000_FFFF : 32'(evcnt_m[d]);
        evcnt_m[d] = ev_entry ? 1 : 0;
`else
        exp = 32'h0;
`endif
      end
    endcase
  endtask

  task automatic access(input int d, input bit is_wr, input logic [1:0] off,
                        input logic [0:31] data, input bit ev_entry, output logic [0:31] rdat);
    int         lat;
    logic [0:9] base;
    base = (d != 0) ? Base1 : Base0;
    rdat = '0;
    @(negedge clk);
    abus[d] = {base[0:7], off};
    dbin[d] = data;
    rd[d]   = !is_wr;
    wr[d]   = is_wr;
    ev[d]   = ev_entry;
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      ev[d] = 1'b0;
      if (get_ack(d) || lat >= 12) break;
    end
    chk("ack_latency", lat, (d != 0) ? 2 : 1);
    if (!is_wr) rdat = get_dbout(d);
    @(negedge clk);
    rd[d]   = 1'b0;
    wr[d]   = 1'b0;
    dbin[d] = $urandom;
    @(posedge clk);
    #1;
    chk("ack_fall", 32'(get_ack(d)), 32'h0);
  endtask

  initial begin
    logic [0:31] rdat, exp, data;
    int          d;
    logic [1:0]  off;
    bit          is_wr;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      abus[i] = '0; dbin[i] = '0; status[i] = '0; rd[i] = 0; wr[i] = 0; ev[i] = 0;
    end
    model_reset();
    dbin[0] = 32'h1357_9BDF;
    #12;
    chk("rst_ack0", 32'(ack0), 32'h0);
    chk("rst_ack1", 32'(ack1), 32'h0);
    chk("rst_ctrl0", ctrl0, 32'h0);
    chk("rst_ctrl1", ctrl1, CtrlRst1);
    chk("rst_passthru", dbout0, 32'h1357_9BDF);
    @(negedge clk);
    rst_n = 1'b1;

    // Write CTRL on the latency-1 instance.
    access(1, 1'b1, 2'd0, 32'hDEAD_BEEF, 1'b0, rdat);
    ctrl_m[1] = 32'hDEAD_BEEF;
    chk("ctrl_deadbeef", ctrl1, 32'hDEAD_BEEF);

    // STATUS read on the latency-0 instance.
    status[0] = 32'h1234_5678;
    access(0, 1'b0, 2'd1, 32'hFFFF_0000, 1'b0, rdat);
    chk("status_read", rdat, 32'h1234_5678);

    // Non-hit address: no ack, data passes through.
    @(negedge clk);
    abus[0] = 10'h3F0; dbin[0] = 32'h0BAD_F00D; rd[0] = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("nohit_ack", 32'(ack0), 32'h0);
      chk("nohit_passthru", dbout0, 32'h0BAD_F00D);
    end
    @(negedge clk);
    rd[0] = 1'b0;

    // Event counting, saturation and clear-on-read.
`ifdef X_DCR_REGFILE_EVCNT_EN
    @(negedge clk); ev[0] = 1'b1;
    repeat (70000) @(negedge clk);
    ev[0] = 1'b0;
    evcnt_m[0] += 70000;
`else
    repeat (20) begin
      @(negedge clk); ev[0] = 1'b1;
      @(negedge clk); ev[0] = 1'b0;
    end
    evcnt_m[0] += 20;
`endif
    access(0, 1'b0, 2'd3, 32'h0, 1'b1, rdat);
    model_read(0, 2'd3, 1'b1, exp);
    chk("evcnt_first", rdat, exp);
    access(0, 1'b0, 2'd3, 32'h0, 1'b0, rdat);
    model_read(0, 2'd3, 1'b0, exp);
    chk("evcnt_second", rdat, exp);

    // Simultaneous read+write is ignored.
    access(1, 1'b1, 2'd2, 32'h1111_2222, 1'b0, rdat);
    scratch_m[1] = 32'h1111_2222;
    @(negedge clk);
    abus[1] = {Base1[0:7], 2'd2}; dbin[1] = 32'hCAFE_F00D; rd[1] = 1'b1; wr[1] = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("both_noack", 32'(ack1), 32'h0);
    end
    @(negedge clk);
    rd[1] = 1'b0; wr[1] = 1'b0;
    access(1, 1'b0, 2'd2, 32'h0, 1'b0, rdat);
    chk("both_scratch", rdat, scratch_m[1]);

    // Request dropped while waiting: aborted, CTRL untouched.
    @(negedge clk);
    abus[1] = {Base1[0:7], 2'd0}; dbin[1] = 32'h0F0F_0F0F; wr[1] = 1'b1;
    @(negedge clk);
    wr[1] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_noack", 32'(ack1), 32'h0);
    end
    chk("abort_ctrl", ctrl1, ctrl_m[1]);

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++) begin
      d     = int'($urandom_range(0, 1));
      off   = 2'($urandom_range(0, 3));
      is_wr = 1'($urandom_range(0, 1));
      data  = $urandom;
      status[d] = $urandom;
      access(d, is_wr, off, data, 1'b0, rdat);
      if (is_wr) begin
        if (off == 2'd0) ctrl_m[d] = data;
        if (off == 2'd2) scratch_m[d] = data;
        chk("rand_ctrl", get_ctrl(d), ctrl_m[d]);
      end else begin
        model_read(d, off, 1'b0, exp);
        chk("rand_read", rdat, exp);
      end
    end

    // Reset asserted while a SCRATCH write is being acknowledged.
    @(negedge clk);
    abus[1] = {Base1[0:7], 2'd2}; dbin[1] = 32'h5555_AAAA; wr[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_ack", 32'(ack1), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", 32'(ack1), 32'h0);
    chk("rst_mid_ctrl", ctrl1, CtrlRst1);
    wr[1] = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 1'b0, 2'd2, 32'h0, 1'b0, rdat);
    chk("rst_scratch", rdat, 32'h0);
    access(0, 1'b0, 2'd0, 32'h0, 1'b0, rdat);
    chk("rst_ctrl0_read", rdat, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
